// File: rtl/xs3_to_bcd_deser.sv
// Serial Excess-3 to packed-BCD receiver.
// Accepts one XS3 digit per handshake, converts it to BCD and shifts it into
// a word of up to DIGITS digits. The finished word is held on a valid/ready
// output port. The block is single-buffered: no input is accepted while a word
// is pending.
module xs3_to_bcd_deser #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_xs3,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [3:0]            out_ndig,
  output logic                  out_err
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t              state_reg;
  logic [4*DIGITS-1:0] word_reg;
  logic [4*DIGITS-1:0] word_next;
  logic [3:0]          count_reg;
  logic [3:0]          count_next;
  logic                err_reg;
  logic                illegal;
  logic [3:0]          bcd_digit;
  logic                word_done;

  // Digit decode: legal XS3 codes are 0x3..0xC; anything else decodes to 0
  // and flags the word as erroneous.
  assign illegal   = (in_xs3 < 4'd3) || (in_xs3 > 4'd12);
  assign bcd_digit = illegal ? 4'd0 : (in_xs3 - 4'd3);

  assign count_next = count_reg + 4'd1;
  assign word_done  = (count_next == 4'(DIGITS)) || in_last;

  // New digit enters at the bottom, so the first-received digit ends up most
  // significant. A one-digit word has nothing to shift.
  generate
    if (DIGITS == 1) begin : g_shift_single
      assign word_next = bcd_digit;
    end else begin : g_shift_multi
      assign word_next = {word_reg[4*DIGITS-5:0], bcd_digit};
    end
  endgenerate

  // Handshake flags come straight from the state register, so neither input
  // valid nor output ready can reach them combinationally.
  assign in_ready  = (state_reg == COLLECT);
  assign out_valid = (state_reg == HOLD);
  assign out_bcd   = word_reg;
  assign out_ndig  = count_reg;
  assign out_err   = err_reg;

  // Collect digits until the word is full or tagged last, then hold it until
  // the consumer takes it; the accumulator is cleared on that same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
      word_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (in_valid) begin
            word_reg  <= word_next;
            count_reg <= count_next;
            err_reg   <= err_reg | illegal;
            if (word_done) begin
              state_reg <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            word_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
            state_reg <= COLLECT;
          end
        end
        default: begin
          state_reg <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xs3_to_bcd_deser.sv
// Bench for xs3_to_bcd_deser (DIGITS=4): directed vectors, an arithmetic
// reference model checked every cycle, and literal expectations per word.
module tb_xs3_to_bcd_deser;

  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [3:0]          in_xs3 = 4'd0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [4*DIGITS-1:0] out_bcd;
  logic [3:0]          out_ndig;
  logic                out_err;

  int n_checks = 0;
  int n_pass   = 0;

  xs3_to_bcd_deser #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_xs3    (in_xs3),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ndig  (out_ndig),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model: word kept as an integer, digits appended arithmetically.
  int  m_word  = 0;
  int  m_n     = 0;
  bit  m_err   = 0;
  bit  m_hold  = 0;
  bit  m_rst   = 0;
  bit  started = 0;

  always @(posedge clk) begin
    int v;
    int d;
    started = 1;
    if (!rst_n) begin
      m_word = 0; m_n = 0; m_err = 0; m_hold = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (!m_hold && in_valid) begin
        v = int'(in_xs3);
        if (v >= 3 && v <= 12) d = v - 3;
        else begin d = 0; m_err = 1; end
        m_word = (m_word * 16 + d) % (1 << (4 * DIGITS));
        m_n++;
        if (m_n == DIGITS || in_last) m_hold = 1;
        $display("accept xs3=%h bcd=%0d count=%0d last=%0b", in_xs3, d, m_n, in_last);
      end else if (m_hold && out_ready) begin
        $display("word out bcd=%h ndig=%0d err=%0b", m_word, m_n, m_err);
        m_word = 0; m_n = 0; m_err = 0; m_hold = 0;
      end
    end
  end

  // Compare process: handshake flags every cycle, data fields whenever they
  // are defined (pending word or reset).
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, !m_hold);
      chk("out_valid", out_valid, m_hold);
      if (m_hold || m_rst) begin
        chk("out_bcd", out_bcd, m_word);
        chk("out_ndig", out_ndig, m_n);
        chk("out_err", out_err, m_err);
      end
    end
  end

  task automatic send(input logic [3:0] x, input logic last);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_xs3 = x; in_last = last;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      n_checks++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_word(input string name, input logic [15:0] bcd,
                          input logic [3:0] nd, input logic err);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_bcd"}, out_bcd, bcd);
    chk({name, "_ndig"}, out_ndig, nd);
    chk({name, "_err"}, out_err, err);
    chk({name, "_model"}, m_word, bcd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with random input activity
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_xs3   = 4'($urandom_range(0, 15));
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_bcd", out_bcd, 16'h0000);
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;

    // 2 + 5: full word then backpressure with inputs still offered
    out_ready = 1'b0;
    send(4'h4, 0); send(4'h5, 0); send(4'h6, 0); send(4'h7, 0);
    @(negedge clk);
    in_xs3 = 4'h8; in_last = 1'b0;
    chk_word("full", 16'h1234, 4'd4, 1'b0);
    chk("full_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_word("bp", 16'h1234, 4'd4, 1'b0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);

    // 3: short word
    out_ready = 1'b1;
    send(4'hC, 0); send(4'h3, 1);
    idle();
    chk_word("short", 16'h0090, 4'd2, 1'b0);
    @(negedge clk);
    chk("short_after_valid", out_valid, 1'b0);
    chk("short_after_ready", in_ready, 1'b1);

    // 4: illegal codes, then a clean word of zeros
    send(4'h4, 0); send(4'h0, 0); send(4'h5, 0); send(4'hF, 0);
    idle();
    chk_word("illegal", 16'h1020, 4'd4, 1'b1);
    send(4'h3, 0); send(4'h3, 0); send(4'h3, 0); send(4'h3, 0);
    idle();
    chk_word("zeros", 16'h0000, 4'd4, 1'b0);

    // 6: reset mid-word discards the partial word
    send(4'h4, 0); send(4'h5, 0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ndig", out_ndig, 4'd0);
    chk("midrst_bcd", out_bcd, 16'h0000);
    send(4'h8, 0); send(4'h9, 0); send(4'hA, 0); send(4'hB, 0);
    idle();
    chk_word("after_rst", 16'h5678, 4'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
